mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (data reads and writes).
- Sequences variable-latency memory handshakes through a small FSM.
- Produces the fetch-stage `imem_r`/`instr` and the pipeline `mem_stall`.
- Data accesses normally win arbitration. A starvation counter guarantees fetch progress. A flush discards an in-flight fetch after a redirect.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/memory pipeline stages, the shared
// memory port and the arbiter that multiplexes them.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              mem_req;
  logic              mem_we;
  logic              mem_byte;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              ram_en;
  logic [1:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_rdata;
  logic              ram_ready;
  logic [15:0]       instr;
  logic              imem_r;
  logic [15:0]       dmem_rdata;
  logic              dmem_r;
  logic              mem_stall;

  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_we, mem_byte, mem_addr,
           mem_wdata, ram_rdata, ram_ready,
    output ram_en, ram_we, ram_addr, ram_wdata, instr, imem_r, dmem_rdata,
           dmem_r, mem_stall
  );

  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_we, mem_byte, mem_addr,
           mem_wdata, ram_rdata, ram_ready,
    input  ram_en, ram_we, ram_addr, ram_wdata, instr, imem_r, dmem_rdata,
           dmem_r, mem_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the memory
// stage; data wins unless fetch has been starved STARVE_LIMIT grants in a row.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t            state;
  logic [CNT_W-1:0]  starve_cnt;
  logic              drop;
  logic              imem_pend;
  logic              dmem_r_q;
  logic              starve_hit;
  logic              grant_d;
  logic              grant_i;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= LIMIT) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [1:0] lane_we(input logic we, input logic byte_acc,
                                         input logic a0);
    if (!we)       return 2'b00;
    if (!byte_acc) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

  assign starve_hit = bus.if_req && (STARVE_LIMIT != 0) && (starve_cnt >= LIMIT);
  assign grant_d    = bus.mem_req && !starve_hit;
  assign grant_i    = !grant_d && bus.if_req && !bus.if_flush;

  // A flush arriving while the completion pulse is up still suppresses it.
  assign bus.imem_r    = imem_pend && !drop && !bus.if_flush;
  assign bus.dmem_r    = dmem_r_q;
  assign bus.mem_stall = bus.mem_req && !dmem_r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      drop           <= 1'b0;
      imem_pend      <= 1'b0;
      dmem_r_q       <= 1'b0;
      bus.ram_en     <= 1'b0;
      bus.ram_we     <= 2'b00;
      bus.ram_addr   <= '0;
      bus.ram_wdata  <= '0;
      bus.instr      <= '0;
      bus.dmem_rdata <= '0;
    end else begin
      imem_pend <= 1'b0;
      dmem_r_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.if_req) starve_cnt <= '0;
          if (grant_d) begin
            state         <= D_BUSY;
            bus.ram_en    <= 1'b1;
            bus.ram_addr  <= {bus.mem_addr[ADDR_W-1:1], 1'b0};
            bus.ram_we    <= lane_we(bus.mem_we, bus.mem_byte, bus.mem_addr[0]);
            bus.ram_wdata <= bus.mem_byte ? {2{bus.mem_wdata[7:0]}} : bus.mem_wdata;
            if (bus.if_req) starve_cnt <= sat_inc(starve_cnt);
          end else if (grant_i) begin
            state        <= I_BUSY;
            bus.ram_en   <= 1'b1;
            bus.ram_addr <= {bus.if_addr[ADDR_W-1:1], 1'b0};
            bus.ram_we   <= 2'b00;
            starve_cnt   <= '0;
          end
        end
        // The dropped fetch still runs to completion so the memory sees a clean handshake.
        I_BUSY: begin
          if (bus.if_flush) drop <= 1'b1;
          if (bus.ram_ready) begin
            bus.instr  <= bus.ram_rdata;
            bus.ram_en <= 1'b0;
            bus.ram_we <= 2'b00;
            imem_pend  <= 1'b1;
            state      <= DONE;
          end
        end
        D_BUSY: begin
          if (bus.ram_ready) begin
            bus.dmem_rdata <= bus.ram_rdata;
            bus.ram_en     <= 1'b0;
            bus.ram_we     <= 2'b00;
            dmem_r_q       <= 1'b1;
            state          <= DONE;
          end
        end
        default: begin
          drop  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, byte write, starvation order,
// flush, asynchronous reset mid-access and back-to-back data requests.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mem_port_arbiter_if #(.ADDR_W(16)) bus ();

  mem_port_arbiter #(.STARVE_LIMIT(2), .ADDR_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  bit exp_i [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.if_flush  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_byte  = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.ram_rdata = '0;
    bus.ram_ready = 1'b0;
    #1;
    chk("rst_ram_en", 32'(bus.ram_en), 32'h0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'h0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
    chk("rst_imem_r", 32'(bus.imem_r), 32'h0);
    chk("rst_dmem_r", 32'(bus.dmem_r), 32'h0);
    chk("rst_instr", 32'(bus.instr), 32'h0);
    chk("rst_stall_idle", 32'(bus.mem_stall), 32'h0);
    bus.mem_req = 1'b1;
    #1;
    chk("rst_stall_req", 32'(bus.mem_stall), 32'h1);
    bus.mem_req = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Fetch only: ready held off for two ram_en cycles
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h3001;
    step();
    chk("f_ram_en", 32'(bus.ram_en), 32'h1);
    chk("f_ram_addr", 32'(bus.ram_addr), 32'h3000);
    chk("f_ram_we", 32'(bus.ram_we), 32'h0);
    step();
    chk("f_wait_imem_r", 32'(bus.imem_r), 32'h0);
    step();
    chk("f_wait2_imem_r", 32'(bus.imem_r), 32'h0);
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 16'h1234;
    step();
    chk("f_imem_r", 32'(bus.imem_r), 32'h1);
    chk("f_instr", 32'(bus.instr), 32'h1234);
    chk("f_ram_en_drop", 32'(bus.ram_en), 32'h0);
    bus.if_req    = 1'b0;
    bus.ram_ready = 1'b0;
    step();
    chk("f_imem_r_once", 32'(bus.imem_r), 32'h0);

    // Byte write to the odd byte
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_byte  = 1'b1;
    bus.mem_addr  = 16'h4005;
    bus.mem_wdata = 16'h00AB;
    #1;
    chk("bw_stall0", 32'(bus.mem_stall), 32'h1);
    step();
    chk("bw_ram_we", 32'(bus.ram_we), 32'h2);
    chk("bw_ram_wdata", 32'(bus.ram_wdata), 32'hABAB);
    chk("bw_ram_addr", 32'(bus.ram_addr), 32'h4004);
    chk("bw_stall1", 32'(bus.mem_stall), 32'h1);
    bus.ram_ready = 1'b1;
    step();
    chk("bw_dmem_r", 32'(bus.dmem_r), 32'h1);
    chk("bw_stall_done", 32'(bus.mem_stall), 32'h0);
    chk("bw_ram_we_drop", 32'(bus.ram_we), 32'h0);
    bus.mem_req   = 1'b0;
    bus.ram_ready = 1'b0;
    step();
    chk("bw_dmem_r_once", 32'(bus.dmem_r), 32'h0);

    // Contention with STARVE_LIMIT = 2: D, D, I, D, D, I
    bus.if_addr   = 16'h1000;
    bus.mem_addr  = 16'h2000;
    bus.mem_we    = 1'b0;
    bus.mem_byte  = 1'b0;
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 16'h1111;
    bus.if_req    = 1'b1;
    bus.mem_req   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("cont_addr", 32'(bus.ram_addr), exp_i[k] ? 32'h1000 : 32'h2000);
      step();
      chk("cont_imem_r", 32'(bus.imem_r), 32'(exp_i[k]));
      chk("cont_dmem_r", 32'(bus.dmem_r), 32'(!exp_i[k]));
      if (exp_i[k]) bus.if_req = 1'b0;
      else          bus.mem_req = 1'b0;
      step();
      bus.if_req  = 1'b1;
      bus.mem_req = 1'b1;
    end
    bus.if_req    = 1'b0;
    bus.mem_req   = 1'b0;
    bus.ram_ready = 1'b0;
    step();
    chk("cont_idle", 32'(bus.ram_en), 32'h0);

    // Flush: blocked in IDLE, then dropped while busy
    bus.if_req   = 1'b1;
    bus.if_addr  = 16'h3100;
    bus.if_flush = 1'b1;
    step();
    chk("fl_idle_block", 32'(bus.ram_en), 32'h0);
    bus.if_flush = 1'b0;
    step();
    chk("fl_ram_en", 32'(bus.ram_en), 32'h1);
    chk("fl_ram_addr", 32'(bus.ram_addr), 32'h3100);
    bus.if_flush = 1'b1;
    step();
    bus.if_flush = 1'b0;
    chk("fl_still_busy", 32'(bus.ram_en), 32'h1);
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 16'hBEEF;
    step();
    chk("fl_imem_r_sup", 32'(bus.imem_r), 32'h0);
    chk("fl_ram_en_drop", 32'(bus.ram_en), 32'h0);
    bus.ram_ready = 1'b0;
    bus.if_addr   = 16'h5000;
    step();
    chk("fl_idle_imem_r", 32'(bus.imem_r), 32'h0);
    step();
    chk("fl_new_addr", 32'(bus.ram_addr), 32'h5000);
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 16'h7777;
    step();
    chk("fl_new_imem_r", 32'(bus.imem_r), 32'h1);
    chk("fl_new_instr", 32'(bus.instr), 32'h7777);
    bus.if_req    = 1'b0;
    bus.ram_ready = 1'b0;
    step();

    // Asynchronous reset during a data access
    bus.mem_req  = 1'b1;
    bus.mem_addr = 16'h0ABC;
    step();
    chk("rm_busy", 32'(bus.ram_en), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("rm_ram_en_async", 32'(bus.ram_en), 32'h0);
    chk("rm_ram_addr", 32'(bus.ram_addr), 32'h0);
    chk("rm_stall", 32'(bus.mem_stall), 32'h1);
    step();
    chk("rm_dmem_r", 32'(bus.dmem_r), 32'h0);
    reset = 1'b0;
    step();
    chk("rm_reissue_en", 32'(bus.ram_en), 32'h1);
    chk("rm_reissue_addr", 32'(bus.ram_addr), 32'h0ABC);
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 16'h5A5A;
    step();
    chk("rm_dmem_r_done", 32'(bus.dmem_r), 32'h1);
    chk("rm_rdata", 32'(bus.dmem_rdata), 32'h5A5A);
    bus.mem_req   = 1'b0;
    bus.ram_ready = 1'b0;
    step();

    // Back-to-back data requests
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_byte  = 1'b0;
    bus.mem_addr  = 16'h0010;
    bus.mem_wdata = 16'hCAFE;
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 16'h0F0F;
    step();
    chk("bb_ram_we", 32'(bus.ram_we), 32'h3);
    chk("bb_ram_wdata", 32'(bus.ram_wdata), 32'hCAFE);
    step();
    chk("bb_dmem_r1", 32'(bus.dmem_r), 32'h1);
    bus.mem_req = 1'b0;
    step();
    chk("bb_no_dup_en", 32'(bus.ram_en), 32'h0);
    chk("bb_no_dup_r", 32'(bus.dmem_r), 32'h0);
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 16'h0020;
    step();
    chk("bb_second_addr", 32'(bus.ram_addr), 32'h0020);
    chk("bb_second_we", 32'(bus.ram_we), 32'h0);
    chk("bb_busy_dmem_r", 32'(bus.dmem_r), 32'h0);
    step();
    chk("bb_dmem_r2", 32'(bus.dmem_r), 32'h1);
    chk("bb_rdata", 32'(bus.dmem_rdata), 32'h0F0F);
    bus.mem_req   = 1'b0;
    bus.ram_ready = 1'b0;
    step();
    chk("bb_dmem_r_once", 32'(bus.dmem_r), 32'h0);
    step();
    chk("bb_idle_en", 32'(bus.ram_en), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
